// File: rtl/mux_n_rr_sel_if.sv
// Handshake bundle between N producer channels, the selector and one consumer.
// The master modport is the driving environment; the slave modport is the selector.
interface mux_n_rr_sel_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
);
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_valid;
  logic [N_CH-1:0]        in_ready;
  logic                   mode;
  logic [SEL_W-1:0]       sel;
  logic [DATA_W-1:0]      out_data;
  logic [SEL_W-1:0]       out_ch;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_n_rr_sel.sv
// N-channel valid/ready selector with fixed-select and round-robin modes,
// feeding a single registered output stage that sustains one word per cycle.
module mux_n_rr_sel #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input logic           clk,
  input logic           rst,
  mux_n_rr_sel_if.slave bus
);

  logic [N_CH-1:0]   w_grant;
  logic [SEL_W-1:0]  w_grantIdx;
  logic [DATA_W-1:0] w_grantData;
  logic [SEL_W-1:0]  w_ptrNext;
  logic              w_load;
  logic              w_xfer;

  logic [SEL_W-1:0]  r_ptr;
  logic [DATA_W-1:0] r_outData;
  logic [SEL_W-1:0]  r_outCh;
  logic              r_outValid;

  assign w_load = ~r_outValid | bus.out_ready;

  // An out-of-range sel matches no channel index, so it grants nothing.
  always_comb begin
    int   idx;
    logic found;
    w_grant = '0;
    found   = 1'b0;
    idx     = 0;
    if (!bus.mode) begin
      for (int i = 0; i < N_CH; i++) begin
        w_grant[i] = (bus.sel == SEL_W'(i)) && bus.in_valid[i];
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        idx = int'(r_ptr) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!found && bus.in_valid[idx]) begin
          w_grant[idx] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_grantIdx  = '0;
    w_grantData = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_grant[i]) begin
        w_grantIdx  = SEL_W'(i);
        w_grantData = bus.in_data[i*DATA_W +: DATA_W];
      end
    end
    if (w_grantIdx == SEL_W'(N_CH - 1)) w_ptrNext = '0;
    else                                w_ptrNext = w_grantIdx + 1'b1;
  end

  assign bus.in_ready = w_grant & {N_CH{w_load & ~rst}};
  assign w_xfer       = (|w_grant) & w_load & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outCh    <= '0;
      r_ptr      <= '0;
    end else if (w_xfer) begin
      r_outValid <= 1'b1;
      r_outData  <= w_grantData;
      r_outCh    <= w_grantIdx;
      if (bus.mode) r_ptr <= w_ptrNext;
    end else if (bus.out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign bus.out_data  = r_outData;
  assign bus.out_ch    = r_outCh;
  assign bus.out_valid = r_outValid;

endmodule

// File: tb/tb_mux_n_rr_sel.sv
// Directed bench: a 4-channel instance for the main function and a 3-channel
// instance for the out-of-range select case.
module tb_mux_n_rr_sel;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  int   checkCount = 0;
  int   failCount  = 0;

  mux_n_rr_sel_if #(.N_CH(4), .DATA_W(8), .SEL_W(2)) busA ();
  mux_n_rr_sel_if #(.N_CH(3), .DATA_W(8), .SEL_W(2)) busB ();

  mux_n_rr_sel #(.N_CH(4), .DATA_W(8), .SEL_W(2)) dutA (
    .clk (clk),
    .rst (rstA),
    .bus (busA.slave)
  );

  mux_n_rr_sel #(.N_CH(3), .DATA_W(8), .SEL_W(2)) dutB (
    .clk (clk),
    .rst (rstB),
    .bus (busB.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic mode, input logic [1:0] sel, input logic outReady);
    busA.in_valid  = valid;
    busA.mode      = mode;
    busA.sel       = sel;
    busA.out_ready = outReady;
  endtask

  // Inputs change 1 time unit after the rising edge; checks sit 2 units later.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rrOrder [4];
    rrOrder = '{3, 1, 3, 1};

    rstA = 1'b1;
    rstB = 1'b1;
    busA.in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    applyStimulus(4'hF, 1'b1, 2'd0, 1'b1);
    busB.in_data   = {8'h32, 8'h31, 8'h30};
    busB.in_valid  = 3'b111;
    busB.mode      = 1'b0;
    busB.sel       = 2'd0;
    busB.out_ready = 1'b1;

    nextCycle(); #2;
    checkOutput("rst_in_ready_c1", 32'(busA.in_ready), 32'h0);
    nextCycle(); #2;
    checkOutput("rst_in_ready_c2", 32'(busA.in_ready), 32'h0);
    checkOutput("rst_out_valid", 32'(busA.out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(busA.out_data), 32'h0);
    checkOutput("rst_out_ch", 32'(busA.out_ch), 32'h0);

    nextCycle();
    rstA = 1'b0;
    #2;
    checkOutput("rr_first_grant", 32'(busA.in_ready), 32'h1);

    for (int k = 0; k < 6; k++) begin
      nextCycle(); #2;
      checkOutput("rr_out_ch", 32'(busA.out_ch), 32'(k % 4));
      checkOutput("rr_out_data", 32'(busA.out_data), 32'('hA0 + 'h11 * (k % 4)));
      checkOutput("rr_out_valid", 32'(busA.out_valid), 32'h1);
    end

    applyStimulus(4'b1010, 1'b1, 2'd0, 1'b1);
    #1;
    checkOutput("sparse_first_grant", 32'(busA.in_ready), 32'b1000);
    for (int k = 0; k < 4; k++) begin
      nextCycle(); #2;
      checkOutput("sparse_out_ch", 32'(busA.out_ch), 32'(rrOrder[k]));
      checkOutput("sparse_even_ready", 32'(busA.in_ready & 4'b0101), 32'h0);
    end

    applyStimulus(4'hF, 1'b0, 2'd0, 1'b1);
    #1;
    checkOutput("fixed_grant_sel0", 32'(busA.in_ready), 32'b0001);
    for (int s = 0; s < 4; s++) begin
      nextCycle(); #2;
      checkOutput("fixed_out_data", 32'(busA.out_data), 32'('hA0 + 'h11 * s));
      checkOutput("fixed_out_ch", 32'(busA.out_ch), 32'(s));
      if (s < 3) busA.sel = 2'(s + 1);
    end

    busA.mode = 1'b1;
    #1;
    checkOutput("ptr_kept_in_fixed", 32'(busA.in_ready), 32'b0100);

    nextCycle();
    busA.in_data[23:16] = 8'h5A;
    applyStimulus(4'hF, 1'b0, 2'd2, 1'b1);
    nextCycle();
    busA.out_ready = 1'b0;
    busA.in_data[23:16] = 8'h77;
    #2;
    for (int k = 0; k < 3; k++) begin
      checkOutput("stall_out_data", 32'(busA.out_data), 32'h5A);
      checkOutput("stall_out_ch", 32'(busA.out_ch), 32'd2);
      checkOutput("stall_out_valid", 32'(busA.out_valid), 32'h1);
      checkOutput("stall_in_ready", 32'(busA.in_ready), 32'h0);
      if (k < 2) begin
        nextCycle(); #2;
      end
    end
    busA.out_ready = 1'b1;
    #1;
    checkOutput("stall_release_ready", 32'(busA.in_ready), 32'b0100);
    nextCycle(); #2;
    checkOutput("after_stall_data", 32'(busA.out_data), 32'h77);
    checkOutput("after_stall_valid", 32'(busA.out_valid), 32'h1);

    busA.in_valid = 4'h0;
    nextCycle(); #2;
    checkOutput("drain_valid", 32'(busA.out_valid), 32'h0);
    checkOutput("drain_data_held", 32'(busA.out_data), 32'h77);

    applyStimulus(4'hF, 1'b0, 2'd1, 1'b1);
    nextCycle();
    busA.out_ready = 1'b0;
    nextCycle(); #2;
    checkOutput("midstall_valid", 32'(busA.out_valid), 32'h1);
    checkOutput("midstall_data", 32'(busA.out_data), 32'hB1);
    rstA = 1'b1;
    #1;
    checkOutput("midstall_rst_ready", 32'(busA.in_ready), 32'h0);
    nextCycle(); #2;
    checkOutput("midstall_rst_valid", 32'(busA.out_valid), 32'h0);
    checkOutput("midstall_rst_data", 32'(busA.out_data), 32'h0);
    rstA = 1'b0;

    rstB = 1'b0;
    #1;
    checkOutput("n3_grant_sel0", 32'(busB.in_ready), 32'b001);
    nextCycle(); #2;
    checkOutput("n3_out_data", 32'(busB.out_data), 32'h30);
    checkOutput("n3_out_valid", 32'(busB.out_valid), 32'h1);
    busB.sel = 2'd3;
    #1;
    checkOutput("n3_oor_ready", 32'(busB.in_ready), 32'h0);
    nextCycle(); #2;
    checkOutput("n3_oor_drained", 32'(busB.out_valid), 32'h0);
    nextCycle(); #2;
    checkOutput("n3_oor_idle_valid", 32'(busB.out_valid), 32'h0);
    checkOutput("n3_oor_idle_ready", 32'(busB.in_ready), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mux_n_rr_sel.md
Name: mux_n_rr_sel

Overview:
- Parametrised N-channel, W-bit-wide data selector with a valid/ready handshake on every input and on the output.
- It has two selection modes. The first is fixed select, which generalises the 4:1 decoder-based mux. The second is round-robin arbitration across all channels.
- Output is registered through one pipeline stage. Full throughput is supported: one word per cycle.
- It sits between multiple producer channels and a single downstream consumer.

Parameters:
- N_CH, 4, number of input channels (2..16).
- DATA_W, 8, width of each channel's data word.
- SEL_W, 2, width of sel/out_ch; must equal ceil(log2(N_CH)).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  N_CH  channel i is presenting a word.
- in_ready  output  N_CH  channel i's word is accepted this cycle.
- mode  input  1  0 = fixed select by sel; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- out_data  output  DATA_W  registered selected word.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_ch are valid.
- out_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
  - in_ready is forced to all-zero combinationally while rst=1.
  - Reset mid-transfer discards the held word; no input is accepted in a reset cycle.
- Load enable: load = ~out_valid | out_ready. The stage can accept a new word when it is empty or being drained in the same cycle.
- Grant (combinational, one-hot or zero, computed every cycle):
  - mode=0: grant[sel]=in_valid[sel] if sel<N_CH. If sel>=N_CH, grant=0 and nothing is accepted.
  - mode=1: scan channels ptr, ptr+1, ..., ptr+N_CH-1 (mod N_CH). Grant the first with in_valid=1. If none are valid, grant=0.
- Handshake and transfer:
  - in_ready[i] = grant[i] & load & ~rst.
  - A transfer on channel g occurs when in_valid[g] & in_ready[g].
  - On the next edge after a transfer: out_data<=in_data[g], out_ch<=g, out_valid<=1.
- Drain: if out_valid & out_ready and there is no new transfer, out_valid<=0. out_data and out_ch hold their last value.
- Stall: while out_valid=1 & out_ready=0, out_data, out_ch and out_valid are held stable and in_ready is all-zero.
- Latency: exactly 1 cycle from input accept to out_valid. Back-to-back transfers sustain 1 word/cycle when out_ready stays high.
- Pointer update:
  - Only in mode=1, and only on a transfer: ptr <= (g+1) mod N_CH. Wrap from N_CH-1 goes to 0.
  - ptr is unchanged in mode=0 and in cycles with no transfer.
- Mode/sel changes take effect in the same cycle's grant computation. A word already in the output register is unaffected.
- in_valid deasserting without a handshake is permitted and causes no error state.
- Simultaneous drain and load: the new word replaces the old one at the edge, and out_valid stays 1.

Test Plan:
- Reset: assert rst 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_ch=0. First grant after release goes to channel 0 (mode=1).
- Fixed select sweep: mode=0, in_data={8'hD3,8'hC2,8'hB1,8'hA0}, all valid, out_ready=1, sel=0,1,2,3 on successive cycles -> out_data A0,B1,C2,D3 with out_ch 0..3, each one cycle after its sel.
- Round-robin fairness: mode=1, all 4 channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, with out_valid held high throughout.
- Sparse round-robin with wrap: mode=1, only ch1 and ch3 valid, ptr=2 -> grant order 3,1,3,1. ch0 and ch2 in_ready are never asserted.
- Backpressure: out_ready=0 for 3 cycles while holding word 8'h5A from ch2 -> out_data=8'h5A and out_ch=2 stay stable, in_ready=0000. The next word is accepted on the cycle out_ready returns to 1.
- Out-of-range/idle: N_CH=3, mode=0, sel=3 with all in_valid=1 -> in_ready=000 and out_valid falls to 0 after draining. Reset asserted mid-stall -> out_valid=0 on the next edge.
